// File: rtl/apb_fifo_ctrl.sv
// apb_fifo_ctrl: synchronous FIFO with a streaming push/pop port and an APB3
// slave for configuration, status, interrupt handling and low-rate data access.
// The head entry is read combinationally so APB DATA reads can return it in
// the same access phase that pops it.
module apb_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [7:0]            PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  irq
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LW         = ADDR_WIDTH + 1;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_THRESH = 8'h08;
    localparam logic [7:0] ADDR_INT    = 8'h0C;
    localparam logic [7:0] ADDR_DATA   = 8'h10;

    // Storage and state
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  enable_q, enable_d;
    logic                  irq_en_q, irq_en_d;
    logic [7:0]            af_thresh_q, af_thresh_d;
    logic [7:0]            ae_thresh_q, ae_thresh_d;
    logic [2:0]            int_stat_q, int_stat_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // Decode and arbitration
    logic                  apb_access, apb_wr, apb_rd;
    logic                  sel_ctrl, sel_status, sel_thresh, sel_int, sel_data, addr_valid;
    logic                  stream_push, stream_pop;
    logic                  apb_push, apb_pop, apb_push_lost, apb_pop_lost;
    logic                  flush;
    logic                  push_req, pop_req, push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] push_data, head;
    logic [7:0]            level8;
    logic                  af_next;
    logic [2:0]            int_set, int_clr;
    logic                  unused_pwdata;

    assign unused_pwdata = ^PWDATA;

    assign apb_access = PSEL & PENABLE;
    assign apb_wr     = apb_access & PWRITE;
    assign apb_rd     = apb_access & ~PWRITE;

    assign sel_ctrl   = (PADDR == ADDR_CTRL);
    assign sel_status = (PADDR == ADDR_STATUS);
    assign sel_thresh = (PADDR == ADDR_THRESH);
    assign sel_int    = (PADDR == ADDR_INT);
    assign sel_data   = (PADDR == ADDR_DATA);
    assign addr_valid = sel_ctrl | sel_status | sel_thresh | sel_int | sel_data;

    // Stream port wins over an APB DATA access in the same direction.
    assign stream_push   = enable_q & wr_en;
    assign stream_pop    = enable_q & rd_en;
    assign apb_push      = apb_wr & sel_data & ~stream_push;
    assign apb_pop       = apb_rd & sel_data & ~stream_pop;
    assign apb_push_lost = apb_wr & sel_data & stream_push;
    assign apb_pop_lost  = apb_rd & sel_data & stream_pop;

    assign flush = apb_wr & sel_ctrl & PWDATA[1];

    assign push_req  = stream_push | apb_push;
    assign pop_req   = stream_pop | apb_pop;
    assign push_data = stream_push ? wr_data : PWDATA[DATA_WIDTH-1:0];
    // Acceptance is judged on the pre-edge occupancy; a flush discards both.
    assign push_ok   = push_req & ~full & ~flush;
    assign pop_ok    = pop_req & ~empty & ~flush;

    assign head   = mem_q[rd_ptr_q];
    assign level8 = 8'(level_q);

    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_full  = (level8 >= af_thresh_q);
    assign almost_empty = (level8 <= ae_thresh_q);

    assign PREADY   = 1'b1;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

    // Next-state computation for pointers, level, registers and flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        af_thresh_d = af_thresh_q;
        ae_thresh_d = ae_thresh_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        int_set     = 3'b000;
        int_clr     = 3'b000;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end

        if (stream_pop && pop_ok) begin
            rd_data_d  = head;
            rd_valid_d = 1'b1;
        end

        if (apb_wr && sel_ctrl) begin
            enable_d = PWDATA[0];
            irq_en_d = PWDATA[2];
        end
        if (apb_wr && sel_thresh) begin
            af_thresh_d = PWDATA[7:0];
            ae_thresh_d = PWDATA[15:8];
        end
        if (apb_wr && sel_int) begin
            int_clr = PWDATA[2:0];
        end

        // The rise is judged against the occupancy and threshold after this edge.
        af_next    = (8'(level_d) >= af_thresh_d);
        int_set[0] = push_req & full & ~flush;
        int_set[1] = pop_req & empty & ~flush;
        int_set[2] = af_next & ~almost_full;

        // A bit being set in the same cycle as its clear stays set.
        int_stat_d = (int_stat_q & ~int_clr) | int_set;
        irq_d      = irq_en_q & (|int_stat_q);
    end

    // APB read data and error response
    always_comb begin
        PRDATA  = 32'h0;
        PSLVERR = 1'b0;
        if (PRESETn && apb_access) begin
            PSLVERR = ~addr_valid | (PWRITE & sel_status) | apb_push_lost
                    | apb_pop_lost | (apb_pop & empty);
        end
        if (PRESETn && apb_rd) begin
            case (PADDR)
                ADDR_CTRL:   PRDATA = {29'h0, irq_en_q, 1'b0, enable_q};
                ADDR_STATUS: PRDATA = {16'h0, level8, 4'h0, almost_full, almost_empty, full, empty};
                ADDR_THRESH: PRDATA = {16'h0, ae_thresh_q, af_thresh_q};
                ADDR_INT:    PRDATA = {29'h0, int_stat_q};
                ADDR_DATA:   PRDATA = (apb_pop && !empty) ? 32'(head) : 32'h0;
                default:     PRDATA = 32'h0;
            endcase
        end
    end

    // Control and status state, cleared asynchronously
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            enable_q    <= 1'b1;
            irq_en_q    <= 1'b0;
            af_thresh_q <= 8'(DEPTH - 2);
            ae_thresh_q <= 8'd1;
            int_stat_q  <= 3'b000;
            irq_q       <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            af_thresh_q <= af_thresh_d;
            ae_thresh_q <= ae_thresh_d;
            int_stat_q  <= int_stat_d;
            irq_q       <= irq_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Entry storage; contents survive reset and flush
    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_apb_fifo_ctrl.sv
// Directed testbench for apb_fifo_ctrl (DATA_WIDTH=8, DEPTH=16).
module tb_apb_fifo_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        wr_en, rd_en;
    logic [7:0]  wr_data, rd_data;
    logic        rd_valid, empty, full, almost_full, almost_empty, irq;

    int checks = 0;
    int errors = 0;

    apb_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_idle();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = 32'h0;
    endtask

    task automatic apb_read(input logic [7:0] a, input logic [31:0] exp,
                            input logic exp_err, input string tag);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        tick();
        PENABLE = 1'b1;
        #1;
        chk(tag, PRDATA, exp);
        chk({tag, "_err"}, {31'h0, PSLVERR}, {31'h0, exp_err});
        tick();
        apb_idle();
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d,
                             input logic exp_err, input string tag);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        #1;
        chk({tag, "_err"}, {31'h0, PSLVERR}, {31'h0, exp_err});
        tick();
        apb_idle();
    endtask

    initial begin
        PRESETn = 1'b0;
        apb_idle();
        wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;

        // Reset state
        #12;
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_ae", {31'h0, almost_empty}, 32'h1);
        chk("rst_af", {31'h0, almost_full}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        tick();
        PRESETn = 1'b1;
        tick();
        apb_read(8'h04, 32'h0000_0005, 1'b0, "rst_status");
        apb_read(8'h00, 32'h0000_0001, 1'b0, "rst_ctrl");
        apb_read(8'h08, 32'h0000_010E, 1'b0, "rst_thresh");

        // Fill 0x01..0x10 through the stream port
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            if (i == 13) chk("af_at_13", {31'h0, almost_full}, 32'h0);
            if (i == 14) chk("af_at_14", {31'h0, almost_full}, 32'h1);
            if (i == 15) chk("full_at_15", {31'h0, full}, 32'h0);
        end
        wr_en = 1'b0;
        chk("full_at_16", {31'h0, full}, 32'h1);
        apb_read(8'h04, 32'h0000_100A, 1'b0, "status_full");
        apb_read(8'h0C, 32'h0000_0004, 1'b0, "int_af_rise");
        wr_en = 1'b1; wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        apb_read(8'h04, 32'h0000_100A, 1'b0, "status_after_ovf");
        apb_read(8'h0C, 32'h0000_0005, 1'b0, "int_ovf");
        apb_write(8'h00, 32'h5, 1'b0, "ctrl_irq_en");
        chk("irq_delay", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_set", {31'h0, irq}, 32'h1);
        apb_write(8'h0C, 32'h5, 1'b0, "w1c");
        tick();
        chk("irq_clr", {31'h0, irq}, 32'h0);
        apb_read(8'h0C, 32'h0, 1'b0, "int_cleared");

        // Drain 16 entries, then one extra pop
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk($sformatf("pop_data_%0d", i), {24'h0, rd_data}, 32'(i));
            chk($sformatf("pop_valid_%0d", i), {31'h0, rd_valid}, 32'h1);
        end
        tick();
        rd_en = 1'b0;
        chk("extra_pop_valid", {31'h0, rd_valid}, 32'h0);
        chk("extra_pop_data", {24'h0, rd_data}, 32'h10);
        chk("drained_empty", {31'h0, empty}, 32'h1);
        apb_read(8'h0C, 32'h0000_0002, 1'b0, "int_udf");
        apb_write(8'h0C, 32'h7, 1'b0, "w1c_all");

        // APB data port
        apb_write(8'h10, 32'hA5, 1'b0, "apb_push");
        apb_read(8'h04, 32'h0000_0104, 1'b0, "status_lvl1");
        apb_read(8'h10, 32'h0000_00A5, 1'b0, "apb_pop");
        apb_read(8'h04, 32'h0000_0005, 1'b0, "status_lvl0");
        apb_read(8'h10, 32'h0, 1'b1, "apb_pop_empty");
        apb_read(8'h0C, 32'h0000_0002, 1'b0, "int_apb_udf");
        apb_write(8'h0C, 32'h7, 1'b0, "w1c_all2");
        apb_read(8'h14, 32'h0, 1'b1, "bad_addr");
        apb_write(8'h04, 32'hFFFF, 1'b1, "status_wr");

        // Move both pointers to 14, then hold 8 entries across the wrap
        for (int i = 0; i < 13; i++) begin
            wr_en = 1'b1; wr_data = 8'h20;
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h48 + k);
            tick();
            chk($sformatf("wrap_data_%0d", k), {24'h0, rd_data}, 32'(8'h40 + k));
        end
        wr_en = 1'b0; rd_en = 1'b0;
        apb_read(8'h04, 32'h0000_0800, 1'b0, "wrap_level");

        // APB DATA write loses to a concurrent stream push
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'hEE;
        tick();
        PENABLE = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        #1;
        chk("apb_push_lost_err", {31'h0, PSLVERR}, 32'h1);
        tick();
        apb_idle();
        wr_en = 1'b0;
        apb_read(8'h04, 32'h0000_0900, 1'b0, "level_9");
        for (int i = 0; i < 9; i++) begin
            rd_en = 1'b1;
            tick();
            chk($sformatf("tail_data_%0d", i), {24'h0, rd_data},
                (i == 8) ? 32'h99 : 32'(8'h54 + i));
        end
        rd_en = 1'b0;
        apb_read(8'h04, 32'h0000_0005, 1'b0, "tail_empty");

        // Flush at level 10 with a concurrent push
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_en = 1'b0;
        apb_read(8'h04, 32'h0000_0A00, 1'b0, "level_10");
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h3;
        tick();
        PENABLE = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        #1;
        chk("flush_err", {31'h0, PSLVERR}, 32'h0);
        tick();
        apb_idle();
        wr_en = 1'b0;
        chk("flush_empty", {31'h0, empty}, 32'h1);
        apb_read(8'h04, 32'h0000_0005, 1'b0, "flush_status");
        apb_read(8'h0C, 32'h0, 1'b0, "flush_no_flags");
        apb_read(8'h00, 32'h0000_0001, 1'b0, "flush_ctrl");

        // Reset in the middle of a burst
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h70 + i);
            tick();
        end
        rd_en = 1'b1;
        tick();
        chk("burst_data", {24'h0, rd_data}, 32'h70);
        chk("burst_valid", {31'h0, rd_valid}, 32'h1);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h04;
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_prdata", PRDATA, 32'h0);
        chk("mid_rst_empty", {31'h0, empty}, 32'h1);
        chk("mid_rst_ae", {31'h0, almost_empty}, 32'h1);
        chk("mid_rst_af", {31'h0, almost_full}, 32'h0);
        chk("mid_rst_valid", {31'h0, rd_valid}, 32'h0);
        chk("mid_rst_data", {24'h0, rd_data}, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        wr_en = 1'b0; rd_en = 1'b0;
        apb_idle();
        tick();
        PRESETn = 1'b1;
        tick();
        apb_read(8'h04, 32'h0000_0005, 1'b0, "post_rst_status");
        apb_read(8'h08, 32'h0000_010E, 1'b0, "post_rst_thresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
